// File: rtl/ext_bus_ctl_if.sv
//-----------------------------------------------------------------------------
// ext_bus_ctl_if
// Bundles the cache external-request handshake (ext*) and the single-ported
// 64-bit memory/peripheral port (mem*) used by ext_bus_ctl.
//
// Signals
//   phi2       ext-bus tick enable
//   extreq     cache request valid           extrdy      controller ready
//   extwr      1=write, 0=read               extreply    read beat valid
//   extaddr    physical byte address         extreplyto  tag of the reply
//   extsz      size code                     extrdata    read beat data
//   extwdata   right-justified write data    exterror    access failed
//   extsrc     requester tag
//   memreq     access request (held)         memack      access complete
//   memwr      write access                  memrdata    read data
//   memaddr    doubleword address            memerr      bus error
//   memwdata   lane-aligned write data
//   memstrb    byte strobes (bit 7 = byte offset 0 = bits 63:56)
//
// Modports
//   slave  : the controller's view (consumes ext requests, drives mem port)
//   master : the environment's view (cache + memory side)
//-----------------------------------------------------------------------------
interface ext_bus_ctl_if #(
    parameter int MAW = 29
);
    logic           phi2;
    logic           extreq;
    logic           extwr;
    logic [31:0]    extaddr;
    logic [4:0]     extsz;
    logic [63:0]    extwdata;
    logic           extsrc;
    logic           extrdy;
    logic           extreply;
    logic           extreplyto;
    logic [63:0]    extrdata;
    logic           exterror;
    logic           memreq;
    logic           memwr;
    logic [MAW-1:0] memaddr;
    logic [63:0]    memwdata;
    logic [7:0]     memstrb;
    logic           memack;
    logic [63:0]    memrdata;
    logic           memerr;

    modport slave (
        input  phi2, extreq, extwr, extaddr, extsz, extwdata, extsrc,
        output extrdy, extreply, extreplyto, extrdata, exterror,
        output memreq, memwr, memaddr, memwdata, memstrb,
        input  memack, memrdata, memerr
    );

    modport master (
        output phi2, extreq, extwr, extaddr, extsz, extwdata, extsrc,
        input  extrdy, extreply, extreplyto, extrdata, exterror,
        input  memreq, memwr, memaddr, memwdata, memstrb,
        output memack, memrdata, memerr
    );
endinterface

// File: rtl/ext_bus_ctl.sv
//-----------------------------------------------------------------------------
// ext_bus_ctl
// Bridges the cache external-request interface to a single-ported 64-bit
// memory port. Cache line fills are issued as multi-beat bursts in
// critical-word order (wrapping within the 32-byte line), uncached reads are
// forwarded as one beat, big-endian partial writes become byte strobes, and
// every memory access is bounded by a timeout reported on exterror.
//
// Ports
//   clk     core clock
//   resetn  asynchronous active-low reset
//   bus     ext_bus_ctl_if.slave (ext request/reply + memory port)
//
// Parameters
//   TOUT  clk cycles memreq may stay unacknowledged before aborting
//   MAW   memory doubleword address width
//-----------------------------------------------------------------------------
module ext_bus_ctl #(
    parameter int TOUT = 255,
    parameter int MAW  = 29
) (
    input  logic          clk,
    input  logic          resetn,
    ext_bus_ctl_if.slave  bus
);

    localparam int CW = $clog2(TOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MREQ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Controller state
    logic [1:0]    r_state;
    logic [28:0]   r_dw;          // latched doubleword address a[31:3]
    logic [4:0]    r_sz;
    logic          r_wr;
    logic          r_src;
    logic [63:0]   r_lane_data;   // write data already moved to its lanes
    logic [7:0]    r_strb;
    logic [1:0]    r_k;           // beat index within a burst
    logic [CW-1:0] r_tcnt;

    // Registered ext-side outputs
    logic          r_extrdy;
    logic          r_extreply;
    logic          r_exterror;
    logic          r_extreplyto;
    logic [63:0]   r_extrdata;

    //-------------------------------------------------------------------------
    // Request decode, evaluated on the incoming request so lanes and strobes
    // are ready before the first memory cycle.
    //-------------------------------------------------------------------------
    logic       w_small;      // sz 0..7: partial access of n = sz+1 bytes
    logic [3:0] w_n;
    logic [3:0] w_span;       // offset + n; more than 8 crosses the dword
    logic [2:0] w_gap;        // unused bytes to the right of the field
    logic       w_bad_wr;
    logic       w_accept;
    logic [63:0] w_lane_data;
    logic [7:0]  w_strb;

    assign w_small  = (bus.extsz[4:3] == 2'b00);
    assign w_n      = 4'(bus.extsz[2:0]) + 4'd1;
    assign w_span   = 4'(bus.extaddr[2:0]) + w_n;
    assign w_gap    = 3'(4'd8 - w_span);
    assign w_bad_wr = bus.extwr &&
                      (w_small ? (w_span > 4'd8) : (bus.extsz != 5'd15));
    assign w_accept = r_extrdy && bus.phi2 && bus.extreq;

    // Big-endian placement: the field ends w_gap bytes above bit 0.
    assign w_lane_data = w_small ? (bus.extwdata << {w_gap, 3'b000})
                                 : bus.extwdata;

    // Strobe bit gi covers byte offset 7-gi; it is set when that offset lies
    // inside [o, o+n-1], i.e. (8-o-n) <= gi <= (7-o).
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_strb
            assign w_strb[gi] = !w_small ||
                ((5'(gi) + 5'(w_span) >= 5'd8) &&
                 (5'(gi) + 5'(bus.extaddr[2:0]) <= 5'd7));
        end
    endgenerate

    //-------------------------------------------------------------------------
    // Burst bookkeeping
    //-------------------------------------------------------------------------
    logic        w_iline;
    logic        w_dline_rd;
    logic        w_last_beat;
    logic [28:0] w_dw;
    logic        w_in_mreq;
    logic        w_tout;

    assign w_iline     = (r_sz == 5'd31);
    assign w_dline_rd  = (r_sz == 5'd15) && !r_wr;
    assign w_last_beat = w_iline    ? (r_k == 2'd3) :
                         w_dline_rd ? (r_k == 2'd1) : 1'b1;
    assign w_in_mreq   = (r_state == ST_MREQ);
    assign w_tout      = (r_tcnt == CW'(TOUT - 1));

    // Critical-word-first addressing: I-lines wrap within the 32-byte line,
    // D-lines visit the requested dword and then its partner.
    always_comb begin
        w_dw = r_dw;
        if (w_iline) begin
            w_dw[1:0] = r_dw[1:0] + r_k;
        end else if (w_dline_rd && r_k[0]) begin
            w_dw[0] = ~r_dw[0];
        end
    end

    //-------------------------------------------------------------------------
    // Memory port: only driven while a request is outstanding
    //-------------------------------------------------------------------------
    assign bus.memreq   = w_in_mreq;
    assign bus.memwr    = w_in_mreq && r_wr;
    assign bus.memaddr  = w_in_mreq ? w_dw[MAW-1:0] : '0;
    assign bus.memwdata = (w_in_mreq && r_wr) ? r_lane_data : '0;
    assign bus.memstrb  = (w_in_mreq && r_wr) ? r_strb : '0;

    assign bus.extrdy     = r_extrdy;
    assign bus.extreply   = r_extreply;
    assign bus.exterror   = r_exterror;
    assign bus.extreplyto = r_extreplyto;
    assign bus.extrdata   = r_extrdata;

    //-------------------------------------------------------------------------
    // Sequencer
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_dw         <= '0;
            r_sz         <= '0;
            r_wr         <= 1'b0;
            r_src        <= 1'b0;
            r_lane_data  <= '0;
            r_strb       <= '0;
            r_k          <= '0;
            r_tcnt       <= '0;
            r_extrdy     <= 1'b0;
            r_extreply   <= 1'b0;
            r_exterror   <= 1'b0;
            r_extreplyto <= 1'b0;
            r_extrdata   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dw        <= bus.extaddr[31:3];
                        r_sz        <= bus.extsz;
                        r_wr        <= bus.extwr;
                        r_src       <= bus.extsrc;
                        r_lane_data <= w_lane_data;
                        r_strb      <= w_strb;
                        r_extrdy    <= 1'b0;
                        r_k         <= '0;
                        r_tcnt      <= '0;
                        if (w_bad_wr) begin
                            // Never reaches memory: report and retire.
                            r_exterror   <= 1'b1;
                            r_extreplyto <= bus.extsrc;
                            r_state      <= ST_RESP;
                        end else begin
                            r_state <= ST_MREQ;
                        end
                    end else begin
                        r_extrdy <= 1'b1;
                    end
                end

                ST_MREQ: begin
                    // An acknowledge on the same edge as the timeout wins.
                    if (bus.memack) begin
                        if (r_wr) begin
                            if (bus.memerr) begin
                                r_exterror   <= 1'b1;
                                r_extreplyto <= r_src;
                                r_state      <= ST_RESP;
                            end else begin
                                r_extrdy <= 1'b1;
                                r_state  <= ST_IDLE;
                            end
                        end else begin
                            r_extrdata   <= bus.memrdata;
                            r_exterror   <= bus.memerr;
                            r_extreply   <= 1'b1;
                            r_extreplyto <= r_src;
                            r_state      <= ST_RESP;
                        end
                    end else if (w_tout) begin
                        r_extrdata   <= '0;
                        r_exterror   <= 1'b1;
                        r_extreply   <= !r_wr;
                        r_extreplyto <= r_src;
                        r_state      <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + CW'(1);
                    end
                end

                ST_RESP: begin
                    // The reply (or bare error) lives for one phi2 tick.
                    if (bus.phi2) begin
                        r_extreply   <= 1'b0;
                        r_exterror   <= 1'b0;
                        r_extreplyto <= 1'b0;
                        if (!r_wr && !r_exterror && !w_last_beat) begin
                            r_k     <= r_k + 2'd1;
                            r_tcnt  <= '0;
                            r_state <= ST_MREQ;
                        end else begin
                            r_extrdy <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_ctl.sv
//-----------------------------------------------------------------------------
// tb_ext_bus_ctl
// Directed and randomized transactions against ext_bus_ctl. A memory
// responder answers memreq with random latency, a monitor collects reply
// ticks, and each transaction is compared with a byte/line level model.
//-----------------------------------------------------------------------------
module tb_ext_bus_ctl;

    localparam int TOUT = 255;
    localparam int MAW  = 29;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    ext_bus_ctl_if #(.MAW(MAW)) bus ();

    ext_bus_ctl #(.TOUT(TOUT), .MAW(MAW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Responder controls
    bit          hold_ack;
    int          err_beat;
    int          max_lat;
    int          ack_idx;
    logic [31:0] salt;

    // Logged memory accesses and reply ticks
    logic [28:0] acc_addr[$];
    logic        acc_wr[$];
    logic [63:0] acc_data[$];
    logic [7:0]  acc_strb[$];
    logic [63:0] rep_data[$];
    logic        rep_err[$];
    logic        rep_tag[$];
    int          werr_ticks;
    int          cur_run;
    int          max_run;

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {salt, 3'b000, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // phi2: random tick enable
    initial begin
        bus.phi2 = 1'b0;
        forever begin
            @(posedge clk);
            #2 bus.phi2 = 1'($urandom_range(0, 1));
        end
    end

    // Memory responder
    initial begin
        int lat;
        int lat_target;
        lat = 0;
        lat_target = 0;
        bus.memack   = 1'b0;
        bus.memerr   = 1'b0;
        bus.memrdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn || !bus.memreq || hold_ack) begin
                bus.memack = 1'b0;
                bus.memerr = 1'b0;
                lat = 0;
            end else if (lat >= lat_target) begin
                bus.memack   = 1'b1;
                bus.memerr   = (ack_idx == err_beat);
                bus.memrdata = mem_word(29'(bus.memaddr));
                acc_addr.push_back(29'(bus.memaddr));
                acc_wr.push_back(bus.memwr);
                acc_data.push_back(bus.memwdata);
                acc_strb.push_back(bus.memstrb);
                ack_idx++;
                lat = 0;
                lat_target = $urandom_range(0, max_lat);
            end else begin
                bus.memack = 1'b0;
                lat++;
            end
        end
    end

    // Reply monitor
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.phi2) begin
                if (bus.extreply) begin
                    rep_data.push_back(bus.extrdata);
                    rep_err.push_back(bus.exterror);
                    rep_tag.push_back(bus.extreplyto);
                end else if (bus.exterror) begin
                    werr_ticks++;
                end
            end
            if (resetn && bus.memreq) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
        end
    end

    task automatic clear_logs();
        acc_addr.delete(); acc_wr.delete(); acc_data.delete(); acc_strb.delete();
        rep_data.delete(); rep_err.delete(); rep_tag.delete();
        werr_ticks = 0;
        max_run = 0;
        ack_idx = 0;
    endtask

    // Present a request and wait until the DUT samples it.
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [4:0] sz,
                         input logic [63:0] wdata, input bit src, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #2;
        bus.extreq = 1'b1; bus.extwr = wr; bus.extaddr = addr;
        bus.extsz = sz; bus.extwdata = wdata; bus.extsrc = src;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.extrdy && bus.phi2) ok = 1'b1;
        end
        @(posedge clk);
        #2 bus.extreq = 1'b0;
        chk("accept", 64'(ok), 64'd1);
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [4:0] sz,
                           input logic [63:0] wdata, input bit src,
                           input int err_b, input bit hold);
        bit ok;
        bit done;
        bit bad;
        int n, o, nb, n_acc, n_rep;
        logic [28:0] ea[4];
        logic [63:0] ed;
        logic [7:0]  es;

        clear_logs();
        err_beat = err_b;
        hold_ack = hold;
        salt = $urandom;

        // Model: size, offset and validity from the size code
        n   = (sz == 5'd15) ? 8 : int'(sz[2:0]) + 1;
        o   = (sz == 5'd15) ? 0 : int'(addr[2:0]);
        bad = wr && !((sz <= 5'd7 && o + n <= 8) || sz == 5'd15);
        nb  = (sz == 5'd31) ? 4 : (sz == 5'd15 && !wr) ? 2 : 1;
        for (int i = 0; i < 4; i++) begin
            if (sz == 5'd31)
                ea[i] = {addr[31:5], 2'(int'(addr[4:3]) + i)};
            else if (sz == 5'd15 && !wr)
                ea[i] = addr[31:3] ^ 29'(i % 2);
            else
                ea[i] = addr[31:3];
        end

        issue(wr, addr, sz, wdata, src, ok);
        done = 1'b0;
        if (ok) begin
            for (int c = 0; c < 2000 && !done; c++) begin
                @(negedge clk);
                if (bus.extrdy) done = 1'b1;
            end
        end
        chk("complete", 64'(done), 64'd1);

        if (bad || hold) n_acc = 0;
        else if (wr) n_acc = 1;
        else n_acc = (err_b < nb) ? err_b + 1 : nb;
        chk("n_access", 64'(acc_addr.size()), 64'(n_acc));

        if (hold) chk("tout_len", 64'(max_run), 64'(TOUT));

        if (wr) begin
            chk("n_reply_wr", 64'(rep_data.size()), 64'd0);
            chk("wr_err_ticks", 64'(werr_ticks), 64'((bad || hold || err_b == 0) ? 1 : 0));
            if (!bad && !hold && acc_addr.size() > 0) begin
                ed = '0;
                es = '0;
                for (int j = 0; j < n; j++) begin
                    ed[8*(7-(o+j)) +: 8] = wdata[8*(n-1-j) +: 8];
                    es[7-(o+j)] = 1'b1;
                end
                chk("wr_addr", 64'(acc_addr[0]), 64'(addr[31:3]));
                chk("wr_flag", 64'(acc_wr[0]), 64'd1);
                chk("wr_data", acc_data[0], ed);
                chk("wr_strb", 64'(acc_strb[0]), 64'(es));
            end
        end else begin
            n_rep = hold ? 1 : n_acc;
            chk("n_reply", 64'(rep_data.size()), 64'(n_rep));
            chk("rd_err_ticks", 64'(werr_ticks), 64'd0);
            for (int i = 0; i < n_rep && i < rep_data.size(); i++) begin
                chk($sformatf("rep%0d_tag", i), 64'(rep_tag[i]), 64'(src));
                chk($sformatf("rep%0d_err", i), 64'(rep_err[i]), 64'((hold || i == err_b) ? 1 : 0));
                if (!hold) begin
                    chk($sformatf("rep%0d_data", i), rep_data[i], mem_word(ea[i]));
                end
            end
            for (int i = 0; i < n_acc && i < acc_addr.size(); i++) begin
                chk($sformatf("rd%0d_addr", i), 64'(acc_addr[i]), 64'(ea[i]));
                chk($sformatf("rd%0d_wr", i), 64'(acc_wr[i]), 64'd0);
            end
        end
        $display("txn wr=%0d addr=%h sz=%0d src=%0d err_b=%0d hold=%0d acc=%0d rep=%0d",
                 wr, addr, sz, src, err_b, hold, acc_addr.size(), rep_data.size());
        hold_ack = 1'b0;
    endtask

    initial begin
        bit ok;
        logic [31:0] a;
        logic [4:0]  sz;
        logic [63:0] wd;
        int kind;

        resetn = 1'b0;
        bus.extreq = 1'b0; bus.extwr = 1'b0; bus.extaddr = '0;
        bus.extsz = '0; bus.extwdata = '0; bus.extsrc = 1'b0;
        hold_ack = 1'b0; err_beat = 99; max_lat = 0; salt = '0;
        ack_idx = 0; werr_ticks = 0; cur_run = 0; max_run = 0;

        #1;
        chk("rst_ctl", 64'({bus.extrdy, bus.extreply, bus.extreplyto, bus.exterror,
                            bus.memreq, bus.memwr, bus.memstrb}), 64'd0);
        chk("rst_data", bus.extrdata | bus.memwdata | 64'(bus.memaddr), 64'd0);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", 64'(bus.extrdy), 64'd0);
        @(negedge clk);
        chk("rdy_after_edge", 64'(bus.extrdy), 64'd1);

        // Directed cases
        run_txn(1'b0, 32'h0000_0048, 5'd31, '0, 1'b1, 99, 1'b0);
        run_txn(1'b0, 32'h0000_0018, 5'd15, '0, 1'b0, 99, 1'b0);
        run_txn(1'b1, 32'h0000_1005, 5'd0, 64'hAB, 1'b1, 99, 1'b0);
        run_txn(1'b1, 32'h0000_0007, 5'd1, 64'h1234, 1'b0, 99, 1'b0);
        run_txn(1'b0, 32'h0000_0048, 5'd31, '0, 1'b0, 1, 1'b0);
        run_txn(1'b1, 32'h0000_0100, 5'd15, 64'h0123_4567_89AB_CDEF, 1'b1, 99, 1'b0);
        run_txn(1'b1, 32'h0000_0200, 5'd31, 64'h55, 1'b0, 99, 1'b0);
        run_txn(1'b1, 32'h0000_0300, 5'd3, 64'hDEAD_BEEF, 1'b1, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0400, 5'd2, '0, 1'b1, 99, 1'b1);

        // Randomized transactions
        max_lat = 3;
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            kind = $urandom_range(0, 4);
            case (kind)
                0: sz = 5'd31;
                1: sz = 5'd15;
                default: sz = 5'($urandom_range(0, 7));
            endcase
            wd = {$urandom, $urandom};
            if (sz <= 5'd7 && sz != 5'd7) wd = wd & ((64'd1 << (8 * (int'(sz) + 1))) - 64'd1);
            run_txn(kind >= 3, a, (kind == 4 && $urandom_range(0, 3) == 0) ? 5'd15 : sz,
                    wd, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 99, 1'b0);
        end

        // Reset in the middle of a burst
        clear_logs();
        hold_ack = 1'b1;
        issue(1'b0, 32'h0000_0060, 5'd31, '0, 1'b1, ok);
        repeat (10) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_ctl", 64'({bus.extrdy, bus.extreply, bus.exterror, bus.memreq}), 64'd0);
        chk("midrst_addr", 64'(bus.memaddr), 64'd0);
        hold_ack = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_rdy", 64'(bus.extrdy), 64'd1);
        chk("midrst_idle", 64'({bus.memreq, bus.extreply}), 64'd0);
        run_txn(1'b0, 32'h0000_0028, 5'd15, '0, 1'b1, 99, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
